// File: rtl/operand_mem_pkg.sv
// Shared constants and state encoding for the operand-pair RAM controller.
package operand_mem_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
    // One extra bit so a full-depth burst length (DEPTH) fits in the pointers.
    localparam int PTR_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2
    } state_t;

endpackage

// File: rtl/operand_out_reg.sv
// Registered output slice towards the FP datapath: holds one operand pair
// with its valid and last flags. A load wins over a pop in the same cycle,
// which gives back-to-back streaming without bubbles.
module operand_out_reg
    import operand_mem_pkg::*;
(
    input  logic              mem_clk,
    input  logic              mem_rst_n,
    input  logic              load,
    input  logic              pop,
    input  logic [DATA_W-1:0] d_opa,
    input  logic [DATA_W-1:0] d_opb,
    input  logic              d_last,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_opa,
    output logic [DATA_W-1:0] out_opb,
    output logic              out_last
);

    // Capture a new pair on load; otherwise drop valid once the pair is taken.
    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            out_valid <= 1'b0;
            out_opa   <= '0;
            out_opb   <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_opa   <= d_opa;
            out_opb   <= d_opb;
            out_last  <= d_last;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/operand_mem_ctrl.sv
// Controller in front of the operand-pair RAM: writes a burst of loader
// pairs to consecutive addresses, then streams them back out in order.
//
// state | meaning
// IDLE  | waiting for mc_start with a non-zero length; RAM controls parked at 0
// LOAD  | accepting loader pairs, one RAM write per handshake at wr_ptr
// READ  | reading pairs at rd_ptr into the output register, draining downstream
module operand_mem_ctrl
    import operand_mem_pkg::*;
(
    input  logic              mem_clk,
    input  logic              mem_rst_n,
    input  logic              mc_start,
    input  logic [ADDR_W:0]   mc_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_opa,
    input  logic [DATA_W-1:0] in_opb,
    output logic [DATA_W-1:0] mem_data_in_opa,
    output logic [DATA_W-1:0] mem_data_in_opb,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mc_address_mem_opa,
    output logic [ADDR_W-1:0] mc_address_mem_opb,
    input  logic [DATA_W-1:0] mem_data_out_opa,
    input  logic [DATA_W-1:0] mem_data_out_opb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_opa,
    output logic [DATA_W-1:0] out_opb,
    output logic              out_last,
    output logic              mc_busy,
    output logic              mc_done
);

    state_t             state_q;
    state_t             state_d;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   len_q;
    logic               done_q;

    logic [PTR_W-1:0]   len_sat;
    logic [ADDR_W-1:0]  addr;
    logic               start_ok;
    logic               load_hs;
    logic               load_done;
    logic               fetch;
    logic               pop;
    logic               read_done;
    logic               fetch_last;

    // Lengths beyond the RAM depth are clipped rather than rejected.
    assign len_sat    = (mc_len > PTR_W'(DEPTH)) ? PTR_W'(DEPTH) : mc_len;
    assign fetch_last = (rd_ptr_q == len_q - PTR_W'(1));

    // FSM state register.
    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the RAM-side controls and handshake strobes.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        addr      = '0;
        start_ok  = 1'b0;
        load_hs   = 1'b0;
        load_done = 1'b0;
        fetch     = 1'b0;
        pop       = 1'b0;
        read_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (mc_start && (mc_len != '0)) begin
                    start_ok = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                mem_we   = in_valid;
                addr     = wr_ptr_q[ADDR_W-1:0];
                load_hs  = in_valid;
                if (in_valid && (wr_ptr_q == len_q - PTR_W'(1))) begin
                    load_done = 1'b1;
                    state_d   = READ;
                end
            end
            READ: begin
                addr  = rd_ptr_q[ADDR_W-1:0];
                fetch = (rd_ptr_q < len_q) && (!out_valid || out_ready);
                pop   = out_valid && out_ready;
                if (out_valid && out_ready && out_last) begin
                    read_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Burst length latch and the write/read pointers.
    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            len_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (start_ok) begin
                len_q    <= len_sat;
                wr_ptr_q <= '0;
            end
            if (load_hs) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (load_done) begin
                rd_ptr_q <= '0;
            end
            if (fetch) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Single-cycle completion pulse after the last pair leaves.
    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= read_done;
        end
    end

    operand_out_reg u_out_reg (
        .mem_clk   (mem_clk),
        .mem_rst_n (mem_rst_n),
        .load      (fetch),
        .pop       (pop),
        .d_opa     (mem_data_out_opa),
        .d_opb     (mem_data_out_opb),
        .d_last    (fetch_last),
        .out_valid (out_valid),
        .out_opa   (out_opa),
        .out_opb   (out_opb),
        .out_last  (out_last)
    );

    assign mem_data_in_opa    = in_opa;
    assign mem_data_in_opb    = in_opb;
    assign mc_address_mem_opa = addr;
    assign mc_address_mem_opb = addr;
    assign mc_busy            = (state_q == LOAD) || (state_q == READ);
    assign mc_done            = done_q;

endmodule

// File: tb/tb_operand_mem_ctrl.sv
// Directed bench for operand_mem_ctrl with a behavioural operand RAM.
module tb_operand_mem_ctrl;

    logic        mem_clk;
    logic        mem_rst_n;
    logic        mc_start;
    logic [6:0]  mc_len;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_opa;
    logic [63:0] in_opb;
    logic [63:0] mem_data_in_opa;
    logic [63:0] mem_data_in_opb;
    logic        mem_we;
    logic [5:0]  mc_address_mem_opa;
    logic [5:0]  mc_address_mem_opb;
    logic [63:0] mem_data_out_opa;
    logic [63:0] mem_data_out_opb;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_opa;
    logic [63:0] out_opb;
    logic        out_last;
    logic        mc_busy;
    logic        mc_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] ram_a [0:63];
    logic [63:0] ram_b [0:63];
    int          wr_cnt   = 0;
    int          max_addr = 0;
    int          hs_cnt   = 0;
    int          done_cnt = 0;
    logic [63:0] cap_a [0:127];
    logic [63:0] cap_b [0:127];
    logic        cap_l [0:127];

    operand_mem_ctrl dut (
        .mem_clk            (mem_clk),
        .mem_rst_n          (mem_rst_n),
        .mc_start           (mc_start),
        .mc_len             (mc_len),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_opa             (in_opa),
        .in_opb             (in_opb),
        .mem_data_in_opa    (mem_data_in_opa),
        .mem_data_in_opb    (mem_data_in_opb),
        .mem_we             (mem_we),
        .mc_address_mem_opa (mc_address_mem_opa),
        .mc_address_mem_opb (mc_address_mem_opb),
        .mem_data_out_opa   (mem_data_out_opa),
        .mem_data_out_opb   (mem_data_out_opb),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_opa            (out_opa),
        .out_opb            (out_opb),
        .out_last           (out_last),
        .mc_busy            (mc_busy),
        .mc_done            (mc_done)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    // Operand RAM: combinational read, write through address A.
    assign mem_data_out_opa = ram_a[mc_address_mem_opa];
    assign mem_data_out_opb = ram_b[mc_address_mem_opb];

    // RAM writes plus observation of writes, output handshakes and done pulses.
    always @(posedge mem_clk) begin
        if (mem_we) begin
            ram_a[mc_address_mem_opa] <= mem_data_in_opa;
            ram_b[mc_address_mem_opa] <= mem_data_in_opb;
            wr_cnt = wr_cnt + 1;
            if (int'(mc_address_mem_opa) > max_addr) max_addr = int'(mc_address_mem_opa);
        end
        if (out_valid && out_ready) begin
            if (hs_cnt < 128) begin
                cap_a[hs_cnt] = out_opa;
                cap_b[hs_cnt] = out_opb;
                cap_l[hs_cnt] = out_last;
            end
            hs_cnt = hs_cnt + 1;
        end
        if (mc_done) done_cnt = done_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout n_checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic start_burst(input logic [6:0] len);
        mc_start = 1'b1;
        mc_len   = len;
        tick();
        mc_start = 1'b0;
        mc_len   = '0;
    endtask

    task automatic load_pair(input logic [63:0] a, input logic [63:0] b, input int exp_addr);
        in_valid = 1'b1;
        in_opa   = a;
        in_opb   = b;
        #1;
        check("load_we", mem_we, 1);
        check("load_ready", in_ready, 1);
        check("load_addr_a", mc_address_mem_opa, exp_addr);
        check("load_addr_b", mc_address_mem_opb, exp_addr);
        check("load_wdata_a", mem_data_in_opa, a);
        check("load_wdata_b", mem_data_in_opb, b);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic read_pair(input logic [63:0] a, input logic [63:0] b, input logic last);
        check("rd_valid", out_valid, 1);
        check("rd_opa", out_opa, a);
        check("rd_opb", out_opb, b);
        check("rd_last", out_last, last);
        tick();
    endtask

    task automatic run_full(input logic [6:0] len);
        int w0;
        w0       = wr_cnt;
        max_addr = 0;
        start_burst(len);
        for (int i = 0; i < 64; i++) load_pair(64'(i), 64'h1000 + 64'(i), i);
        #1;
        check("full_in_read_busy", mc_busy, 1);
        check("full_in_read_ready", in_ready, 0);
        check("full_writes", wr_cnt - w0, 64);
        check("full_max_addr", max_addr, 63);
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) read_pair(64'(i), 64'h1000 + 64'(i), i == 63);
        check("full_done", mc_done, 1);
        check("full_busy_low", mc_busy, 0);
        tick();
    endtask

    initial begin
        int w0;
        int h0;
        int d0;
        bit done_seen;

        mem_rst_n = 1'b0;
        mc_start  = 1'b0;
        mc_len    = '0;
        in_valid  = 1'b0;
        in_opa    = '0;
        in_opb    = '0;
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_opa", out_opa, 0);
        check("rst_out_last", out_last, 0);
        check("rst_done", mc_done, 0);
        check("rst_busy", mc_busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr_a", mc_address_mem_opa, 0);
        check("rst_addr_b", mc_address_mem_opb, 0);
        tick();
        mem_rst_n = 1'b1;
        tick();

        // Burst of four with the downstream always ready.
        w0 = wr_cnt;
        d0 = done_cnt;
        start_burst(7'd4);
        check("b4_busy", mc_busy, 1);
        for (int i = 0; i < 4; i++) load_pair(64'(2*i+1), 64'(2*i+2), i);
        #1;
        check("b4_enter_read_valid", out_valid, 0);
        check("b4_read_we", mem_we, 0);
        check("b4_read_ready", in_ready, 0);
        check("b4_read_addr", mc_address_mem_opa, 0);
        check("b4_writes", wr_cnt - w0, 4);
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) read_pair(64'(2*i+1), 64'(2*i+2), i == 3);
        check("b4_done", mc_done, 1);
        check("b4_valid_low", out_valid, 0);
        check("b4_busy_low", mc_busy, 0);
        tick();
        check("b4_done_pulse", mc_done, 0);
        check("b4_done_count", done_cnt - d0, 1);

        // Backpressure: stall five cycles, then alternate ready.
        out_ready = 1'b0;
        h0 = hs_cnt;
        start_burst(7'd3);
        for (int i = 0; i < 3; i++) load_pair(64'h10 + 64'(i), 64'h20 + 64'(i), i);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_stall_valid", out_valid, 1);
            check("bp_stall_opa", out_opa, 64'h10);
            check("bp_stall_opb", out_opb, 64'h20);
            check("bp_stall_last", out_last, 0);
            tick();
        end
        done_seen = 1'b0;
        for (int k = 0; k < 30 && !done_seen; k++) begin
            out_ready = (k % 2 == 0);
            tick();
            if (mc_done) done_seen = 1'b1;
        end
        out_ready = 1'b0;
        check("bp_done_seen", done_seen, 1);
        check("bp_handshakes", hs_cnt - h0, 3);
        for (int j = 0; j < 3; j++) begin
            check("bp_cap_opa", cap_a[h0+j], 64'h10 + 64'(j));
            check("bp_cap_opb", cap_b[h0+j], 64'h20 + 64'(j));
            check("bp_cap_last", cap_l[h0+j], j == 2);
        end
        tick();

        // Full depth, then an over-long length that must saturate.
        run_full(7'd64);
        run_full(7'd100);

        // Ignored inputs while idle and a restart attempt during LOAD.
        out_ready = 1'b0;
        w0 = wr_cnt;
        in_valid  = 1'b1;
        in_opa    = 64'hdead;
        in_opb    = 64'hbeef;
        mc_start  = 1'b1;
        mc_len    = 7'd0;
        #1;
        check("ign_idle_we", mem_we, 0);
        check("ign_idle_ready", in_ready, 0);
        tick();
        mc_start = 1'b0;
        in_valid = 1'b0;
        check("ign_len0_busy", mc_busy, 0);
        check("ign_idle_writes", wr_cnt - w0, 0);
        start_burst(7'd3);
        mc_start = 1'b1;
        mc_len   = 7'd5;
        #1;
        check("ign_load_we", mem_we, 0);
        check("ign_load_ready", in_ready, 1);
        tick();
        mc_start = 1'b0;
        mc_len   = '0;
        check("ign_load_busy", mc_busy, 1);
        check("ign_load_addr", mc_address_mem_opa, 0);

        // Loader gaps: valid pattern 1,0,1,0,1.
        load_pair(64'h31, 64'h41, 0);
        #1;
        check("gap_we0", mem_we, 0);
        check("gap_addr1", mc_address_mem_opa, 1);
        tick();
        load_pair(64'h32, 64'h42, 1);
        #1;
        check("gap_we1", mem_we, 0);
        check("gap_addr2", mc_address_mem_opa, 2);
        tick();
        load_pair(64'h33, 64'h43, 2);
        check("gap_writes", wr_cnt - w0, 3);
        out_ready = 1'b1;
        tick();
        read_pair(64'h31, 64'h41, 1'b0);
        read_pair(64'h32, 64'h42, 1'b0);
        read_pair(64'h33, 64'h43, 1'b1);
        check("gap_done", mc_done, 1);
        tick();

        // Asynchronous reset in the middle of READ.
        out_ready = 1'b0;
        start_burst(7'd4);
        for (int i = 0; i < 4; i++) load_pair(64'hA0 + 64'(i), 64'hC0 + 64'(i), i);
        tick();
        check("ar_pre_valid", out_valid, 1);
        #2;
        mem_rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 0);
        check("ar_busy", mc_busy, 0);
        check("ar_addr_a", mc_address_mem_opa, 0);
        check("ar_addr_b", mc_address_mem_opb, 0);
        check("ar_opa", out_opa, 0);
        tick();
        mem_rst_n = 1'b1;
        tick();
        start_burst(7'd2);
        load_pair(64'hB0, 64'hD0, 0);
        load_pair(64'hB1, 64'hD1, 1);
        check("ar_ram_a0", ram_a[0], 64'hB0);
        check("ar_ram_b1", ram_b[1], 64'hD1);
        out_ready = 1'b1;
        tick();
        read_pair(64'hB0, 64'hD0, 1'b0);
        read_pair(64'hB1, 64'hD1, 1'b1);
        check("ar_done", mc_done, 1);
        check("ar_busy_end", mc_busy, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_mem_ctrl.md
Name: operand_mem_ctrl

Overview:
- Controller directly upstream of the 64x64 operand-pair RAM.
- Accepts a burst of (opa, opb) pairs from the loader stream and writes them to consecutive RAM addresses.
- Then reads the pairs back in order and presents them, registered, to the downstream FP datapath over a valid/ready handshake.
- Drives all RAM control: mem_we, mc_address_mem_opa and mc_address_mem_opb. The RAM read path is combinational.

Parameters:
- DATA_W, 64, operand width (opa and opb each).
- ADDR_W, 6, RAM address width.
- DEPTH, 64, RAM entries; must equal 2**ADDR_W.

Ports:
- mem_clk  in  1  single clock; all state updates on its rising edge.
- mem_rst_n  in  1  asynchronous, active-low reset.
- mc_start  in  1  one-cycle pulse; starts a burst, sampled only in IDLE.
- mc_len  in  ADDR_W+1  number of pairs in the burst, sampled with mc_start.
- in_valid  in  1  loader pair valid.
- in_ready  out  1  controller accepts a pair.
- in_opa  in  DATA_W  loader operand A.
- in_opb  in  DATA_W  loader operand B.
- mem_data_in_opa  out  DATA_W  RAM write data A.
- mem_data_in_opb  out  DATA_W  RAM write data B.
- mem_we  out  1  RAM write enable.
- mc_address_mem_opa  out  ADDR_W  RAM address A; also the write address.
- mc_address_mem_opb  out  ADDR_W  RAM read address B.
- mem_data_out_opa  in  DATA_W  RAM read data A (combinational).
- mem_data_out_opb  in  DATA_W  RAM read data B (combinational).
- out_valid  out  1  downstream pair valid.
- out_ready  in  1  downstream accepts the pair.
- out_opa  out  DATA_W  registered operand A.
- out_opb  out  DATA_W  registered operand B.
- out_last  out  1  marks the final pair of the burst.
- mc_busy  out  1  high in LOAD or READ.
- mc_done  out  1  one-cycle pulse after the final output handshake.

Behaviour:
- Reset (async, mem_rst_n=0):
  - state=IDLE; wr_ptr, rd_ptr, len_q = 0.
  - out_valid, out_opa, out_opb, out_last, mc_done = 0.
  - Combinational outputs settle to their IDLE values.
  - RAM contents are not cleared. Reset mid-burst abandons the burst.
- States:
  - IDLE:
    - in_ready=0, mem_we=0, both addresses=0.
    - mc_start with mc_len=0: ignored, stay in IDLE.
    - mc_start with mc_len>DEPTH: len_q saturates to DEPTH.
    - Otherwise: len_q=mc_len, wr_ptr=0, go to LOAD.
  - LOAD:
    - in_ready=1; mem_we = in_valid (combinational).
    - Both addresses = wr_ptr[ADDR_W-1:0]; mem_data_in_* = in_op* (pass-through).
    - On each handshake, wr_ptr increments.
    - On the handshake with wr_ptr==len_q-1: go to READ, rd_ptr=0.
  - READ:
    - in_ready=0, mem_we=0; both addresses = rd_ptr[ADDR_W-1:0].
    - Fetch condition: rd_ptr<len_q and (!out_valid or out_ready).
    - On fetch: out_op* <= mem_data_out_op*; out_valid<=1; out_last<=(rd_ptr==len_q-1); rd_ptr++.
    - If out_valid and out_ready and no fetch: out_valid<=0.
    - On the handshake where out_last=1: out_valid<=0, mc_done<=1 for one cycle, go to IDLE.
- Latency:
  - One cycle after entering READ, out_valid rises with pair 0.
  - With out_ready held high, throughput is one pair per cycle and no bubbles.
  - out_op* and out_last hold stable while out_valid=1 and out_ready=0.
- mc_start while mc_busy=1: ignored.
- mc_busy = (state==LOAD or state==READ).
- Width rules:
  - Pointers are ADDR_W+1 bits, so len_q=64 is representable.
  - Addresses are the low ADDR_W bits; no wrap occurs within a burst.
- in_valid outside LOAD: ignored, no write.
- out_ready while out_valid=0: no effect.

Decomposition:
- Package operand_mem_pkg:
  - DATA_W, ADDR_W, DEPTH constants.
  - State enum: IDLE, LOAD, READ.
- Sub-module operand_out_reg: the registered output slice holding out_opa, out_opb, out_valid and out_last, with load and pop control.
- Address/we muxing and the FSM stay in the top module.

Test Plan:
- Burst of 4 pairs, out_ready=1:
  - Stimulus: mc_start, mc_len=4; pairs (0x1,0x2), (0x3,0x4), (0x5,0x6), (0x7,0x8), in_valid=1 continuously.
  - Response: 4 writes at addresses 0..3, mem_we high for exactly 4 cycles.
  - Response: out_valid rises one cycle after entering READ; pairs emerge in order on consecutive cycles; out_last only on (0x7,0x8).
  - Response: mc_done pulses once; mc_busy falls.
- Backpressure:
  - Stimulus: mc_len=3; out_ready low for 5 cycles, then toggling.
  - Response: out_op* held stable while stalled; exactly 3 handshakes; no pair dropped or duplicated.
- Full depth:
  - Stimulus: mc_len=64, then mc_len=100; data = address index.
  - Response: addresses reach 63 with no wrap; out_last on pair 63; mc_len=100 behaves identically to 64.
- Ignored inputs:
  - Stimulus: mc_len=0 start; mc_start during LOAD; in_valid while IDLE.
  - Response: no state change, mem_we=0, in_ready=0.
- Loader gaps:
  - Stimulus: in_valid toggling 1,0,1,0 during LOAD.
  - Response: writes only on valid cycles; wr_ptr gap-free.
- Async reset:
  - Stimulus: assert mem_rst_n=0 mid-READ, between clock edges.
  - Response: out_valid=0, mc_busy=0, addresses=0 immediately.
  - Response: a new burst then runs correctly, overwriting the RAM.
